// File: rtl/eco32f_icache_refill.sv
// Instruction-cache line refill engine: critical-word-first wrapping Wishbone B3 burst.
// Optional retry support is compiled in with `define ECO32F_IREFILL_RETRY_EN.
module eco32f_icache_refill #(
  parameter int LINE_WORDS      = 8,
  parameter int RESET_BTE_CHECK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  input  logic                  abort,
  output logic                  wr_en,
  output logic [31:0]           wr_addr,
  output logic [31:0]           wr_data,
  output logic [LINE_WORDS-1:0] word_valid,
  output logic                  done,
  output logic                  bus_err,
  output logic [31:0]           iwbm_adr_o,
  output logic                  iwbm_stb_o,
  output logic                  iwbm_cyc_o,
  output logic [3:0]            iwbm_sel_o,
  output logic                  iwbm_we_o,
  output logic [2:0]            iwbm_cti_o,
  output logic [1:0]            iwbm_bte_o,
  output logic [31:0]           iwbm_dat_o,
  input  logic                  iwbm_ack_i,
  input  logic                  iwbm_err_i,
  input  logic                  iwbm_rty_i,
  input  logic [31:0]           iwbm_dat_i
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam logic [OW-1:0] CNT_INIT = OW'(LINE_WORDS - 1);
  localparam logic [OW-1:0] ONE = OW'(1);
  localparam logic [1:0] BTE = (LINE_WORDS == 4) ? 2'b01 :
                               (LINE_WORDS == 8) ? 2'b10 : 2'b11;

  if (RESET_BTE_CHECK != 0 && LINE_WORDS != 4 &&
      LINE_WORDS != 8 && LINE_WORDS != 16) begin : g_bad_lw
    $error("eco32f_icache_refill: LINE_WORDS must be 4, 8 or 16");
  end

`ifdef ECO32F_IREFILL_RETRY_EN
  typedef enum logic [1:0] {IDLE, REFILL, RETRY_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REFILL} state_t;
`endif

  state_t                state, state_n;
  logic [31:0]           adr, adr_n;
  logic [OW-1:0]         cnt, cnt_n;
  logic [LINE_WORDS-1:0] wv_n;
  logic                  wr_en_n, done_n, err_n;
  logic [31:0]           wr_addr_n, wr_data_n;
  logic                  t_abort, t_err, t_rty, t_ack;
  logic                  unused_ok;

  assign unused_ok = ^req_addr[1:0];

  assign req_ready  = (state == IDLE) & ~rst;
  assign iwbm_cyc_o = (state == REFILL);
  assign iwbm_stb_o = (state == REFILL);
  assign iwbm_adr_o = adr;
  assign iwbm_sel_o = 4'b1111;
  assign iwbm_we_o  = 1'b0;
  assign iwbm_dat_o = 32'd0;
  assign iwbm_bte_o = BTE;
  assign iwbm_cti_o = (state == REFILL && cnt != '0) ? 3'b010 : 3'b111;

  // Mutually exclusive bus events: abort > err > rty > ack.
  assign t_abort = abort;
  assign t_err   = ~abort & iwbm_err_i;
  assign t_rty   = ~abort & ~iwbm_err_i & iwbm_rty_i;
  assign t_ack   = ~abort & ~iwbm_err_i & ~iwbm_rty_i & iwbm_ack_i;

  always_comb begin
    state_n   = state;
    adr_n     = adr;
    cnt_n     = cnt;
    wv_n      = word_valid;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    done_n    = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && !abort) begin
          state_n = REFILL;
          adr_n   = {req_addr[31:2], 2'b00};
          cnt_n   = CNT_INIT;
          wv_n    = '0;
        end
      end
      REFILL: begin
        unique case (1'b1)
          t_abort: begin
            state_n = IDLE;
            wv_n    = '0;
          end
          t_err: begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
          t_rty: begin
`ifdef ECO32F_IREFILL_RETRY_EN
            state_n = RETRY_WAIT;
`else
            state_n = IDLE;
            err_n   = 1'b1;
`endif
          end
          t_ack: begin
            wr_en_n   = 1'b1;
            wr_addr_n = adr;
            wr_data_n = iwbm_dat_i;
            wv_n[adr[OW+1:2]] = 1'b1;
            // Wrap the word offset inside the line, keep the line base.
            adr_n[OW+1:2] = adr[OW+1:2] + ONE;
            if (cnt == '0) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              cnt_n = cnt - ONE;
            end
          end
          default: ;
        endcase
      end
`ifdef ECO32F_IREFILL_RETRY_EN
      RETRY_WAIT: begin
        if (abort) begin
          state_n = IDLE;
          wv_n    = '0;
        end else begin
          state_n = REFILL;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      adr        <= '0;
      cnt        <= '0;
      word_valid <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_n;
      adr        <= adr_n;
      cnt        <= cnt_n;
      word_valid <= wv_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      done       <= done_n;
      bus_err    <= err_n;
    end
  end

endmodule
